// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states, byte-lane swap.
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Core order keeps byte 0 in [7:0]; memory order keeps byte 0 in [31:24].
  function automatic logic [XLEN-1:0] lane_swap(input logic [XLEN-1:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane steering: load extraction/extension and SB/SH read-modify-write merge.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] read_word,
  input  logic [XLEN-1:0] merge_word,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_value,
  output logic [XLEN-1:0] merged_word
);

  logic [BYTE_W-1:0] lo_byte;
  logic [HALF_W-1:0] lo_half;

  assign lo_byte = read_word[31:24];
  assign lo_half = {read_word[23:16], read_word[31:24]};

  always_comb begin
    load_value = '0;
    case (funct3)
      F3_B:    load_value = {{(XLEN-BYTE_W){lo_byte[BYTE_W-1]}}, lo_byte};
      F3_BU:   load_value = {{(XLEN-BYTE_W){1'b0}}, lo_byte};
      F3_H:    load_value = {{(XLEN-HALF_W){lo_half[HALF_W-1]}}, lo_half};
      F3_HU:   load_value = {{(XLEN-HALF_W){1'b0}}, lo_half};
      F3_W:    load_value = lane_swap(read_word);
      default: load_value = '0;
    endcase
  end

  // Only the addressed bytes are replaced; the rest come back unchanged from the read.
  always_comb begin
    merged_word = merge_word;
    case (funct3)
      F3_B:    merged_word = {store_data[7:0], merge_word[23:0]};
      F3_H:    merged_word = {store_data[7:0], store_data[15:8], merge_word[15:0]};
      default: merged_word = merge_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit with RMW sub-word stores; resp 1 cycle after accept on fault, 2 for loads/SW, 3 for SB/SH.
// One request in flight, req_ready only in IDLE, no resp backpressure; LSU_MISALIGN_TRAP_EN faults misaligned H/W accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N         = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_error,
  output logic [N-1:0] mem_addr,
  output logic         mem_write_enable,
  output logic [N-1:0] mem_write_data,
  input  logic [N-1:0] mem_read_data
);

  localparam logic [N-1:0] ADDR_MAX = N'(MEM_BYTES - 4);

  lsu_state_t   state;
  logic         write_q;
  logic [2:0]   funct3_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] merge_q;
  logic [N-1:0] load_value;
  logic [N-1:0] merged_word;
  logic         bad_funct3;
  logic         misalign;
  logic         fault;

  always_comb begin
    bad_funct3 = 1'b1;
    if (req_write) begin
      bad_funct3 = (req_funct3 > F3_W);
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: bad_funct3 = 1'b0;
        default:                        bad_funct3 = 1'b1;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault = bad_funct3 || (req_addr > ADDR_MAX) || misalign;

  lsu_lane_merge u_lane_merge (
    .funct3      (funct3_q),
    .read_word   (mem_read_data),
    .merge_word  (merge_q),
    .store_data  (wdata_q),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  // Memory strobes decode from state so an async reset kills a pending write before the next edge.
  assign req_ready        = (state == IDLE);
  assign mem_addr         = (state == ACCESS || state == WRITE) ? addr_q : '0;
  assign mem_write_enable = (state == WRITE) ||
                            (state == ACCESS && write_q && funct3_q == F3_W);
  assign mem_write_data   = (state == WRITE) ? merged_word :
                            (mem_write_enable ? lane_swap(wdata_q) : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!write_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_value;
          end else if (funct3_q == F3_W) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= '0;
          end else begin
            merge_q <= mem_read_data;
            state   <= WRITE;
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state      <= IDLE;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory stage and the byte-addressed data memory.
- Decodes RV32I load/store width and sign from funct3 and performs little-endian lane swapping.
- The data memory has no byte strobes, so sub-word stores are done as read-modify-write (RMW).
- Flags out-of-range and illegal accesses; one request in flight, fixed-latency response.

Parameters:
N, 32, datapath/address width
MEM_BYTES, 256, data memory depth in bytes; window addr..addr+3 must lie inside

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  LSU idle and can accept a request
req_write  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  N  byte address
req_wdata  input  N  store data, little-endian, value in LSBs
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  N  load result, sign/zero extended; 0 for stores and errors
resp_error  output  1  access fault or illegal funct3, valid with resp_valid
mem_addr  output  N  byte address to data memory
mem_write_enable  output  1  memory write strobe, sampled on posedge clk
mem_write_data  output  N  memory-order word; byte addr+0 in [31:24]
mem_read_data  input  N  combinational memory read, same byte order

Behaviour:
- Reset (rst=0, async): state=IDLE; resp_valid=0, resp_error=0, resp_rdata=0, mem_write_enable=0, mem_addr=0, mem_write_data=0; req_ready=1 once released.
- Lane swap: core value V maps to memory word {V[7:0],V[15:8],V[23:16],V[31:24]}, and the same mapping applies in reverse on reads.
- States IDLE, ACCESS, WRITE, RESP; req_ready=1 only in IDLE.
- IDLE:
  - On req_valid, latch write/funct3/addr/wdata.
  - Illegal funct3 (load 011/110/111, store >=011) or req_addr > MEM_BYTES-4 -> RESP with error.
  - Otherwise -> ACCESS.
- ACCESS: mem_addr = latched addr.
  - Load: capture the extracted, extended value -> RESP.
  - SW: mem_write_enable=1 with the swapped wdata -> RESP.
  - SB/SH: capture mem_read_data into the merge register -> WRITE.
- WRITE:
  - SB replaces [31:24] of the merge register with wdata[7:0].
  - SH replaces [31:16] with {wdata[7:0],wdata[15:8]}.
  - mem_write_enable=1 with the merged word -> RESP.
- Extraction:
  - LB/LBU use rd[31:24].
  - LH/LHU use {rd[23:16],rd[31:24]}.
  - LW uses the full swap.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. No backpressure on resp.
- Latency from accept edge:
  - Load and SW: resp_valid 2 cycles later.
  - SB/SH: 3 cycles later.
  - Error: 1 cycle later.
- mem_write_enable is decoded from state, so async reset during ACCESS/WRITE drops it before the next edge and no partial write occurs.
- Boundaries:
  - addr = MEM_BYTES-4 is legal; MEM_BYTES-3 and above faults.
  - Address arithmetic never wraps.
  - Errors never assert mem_write_enable.

Optional Feature:
LSU_MISALIGN_TRAP_EN:
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, give resp_error after 1 cycle with no memory access.
- Undefined: these accesses proceed byte-granular with the normal latency.

Decomposition:
- lsu_pkg: funct3 enum, lsu_state_t enum, lane_swap function, width/extend constants.
- Sub-module lsu_lane_merge (combinational): extraction/extension for loads and SB/SH merge; the FSM stays in load_store_unit.

Test Plan:
- SW addr 0x10 wdata 0x11223344 -> mem_write_data 0x44332211 at mem_addr 0x10; resp_valid 2 cycles after accept, resp_error=0.
- After SW, LB 0x11 -> 0x00000033; LBU 0x13 -> 0x00000011; LW 0x10 -> 0x11223344.
- SB 0x12 wdata 0x000000AA -> one read then one write, resp at +3 cycles; LW 0x10 -> 0x11AA3344; LH 0x11 -> 0xFFFFAA33 (macro undefined).
- LW 0xFD and LW 0xFC with MEM_BYTES=256:
  - 0xFD -> resp_error=1 after 1 cycle, mem_write_enable never high.
  - 0xFC -> succeeds.
- Illegal funct3 011 on load -> resp_error=1, resp_rdata=0. With LSU_MISALIGN_TRAP_EN, LH 0x11 -> resp_error=1.
- rst low mid-SB while in WRITE state -> mem_write_enable=0 immediately; after release req_ready=1 and LW 0x10 returns the pre-store value.
